// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral
//   Memory-mapped UART transmitter on the CPU data bus. Stores to TXDATA push
//   bytes into a TX FIFO. A bit-serial FSM drains the FIFO as 8N1 frames on tx,
//   or as 8E1 frames when the parity option is built in.
//   STATUS and CTRL reads are combinational, so a load completes in its MEM cycle.
//
//   Build option: define UART_TX_PARITY_EN to add an even-parity bit between
//   the data bits and the stop bit (11-bit frame).
//
//   Register map (byte offsets from BASE_ADDR):
//     +0 TXDATA  W   Write_data[7:0] pushed to the FIFO; reads 0
//     +4 STATUS  R   {count[8:4], overflow[3], empty[2], full[1], busy[0]}
//     +8 CTRL    RW  bit0 irq_en; writing bit1=1 clears overflow (reads 0)
//
//   Ports:
//     clk         system clock
//     reset       synchronous, active-high reset
//     Address     bus byte address (exact 32-bit decode)
//     Write_data  bus store data
//     MemRead     bus load strobe
//     MemWrite    bus store strobe
//     Read_data   combinational load data, 0 when not selected
//     tx          serial line, idle high (registered)
//     irq         level interrupt: irq_en & empty & ~busy (registered)
module uart_tx_peripheral #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020,
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'd8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic sel_data;
  logic sel_stat;
  logic sel_ctrl;
  logic push_req;
  logic ctrl_wr;

  assign sel_data = (Address == ADDR_DATA);
  assign sel_stat = (Address == ADDR_STAT);
  assign sel_ctrl = (Address == ADDR_CTRL);
  assign push_req = MemWrite & sel_data;
  assign ctrl_wr  = MemWrite & sel_ctrl;

  // Only the low byte of a store carries payload.
  logic unused_bits;
  assign unused_bits = ^Write_data[31:8];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // A pop on the same edge frees the slot, so a push while full still fits.
  assign push  = push_req & (~full | pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= Write_data[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control / sticky overflow
  // ---------------------------------------------------------------------------
  logic irq_en;
  logic overflow;
  logic ovf_set;

  assign ovf_set = push_req & full & ~pop;

  // A new overflow on the same edge as a clear request takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en <= Write_data[0];
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ctrl_wr && Write_data[1]) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_next;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_next;
  logic [7:0]  shreg;
  logic        baud_done;
  logic        busy;
  logic        tx_next;
  logic        irq_next;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign busy      = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the FIFO head is popped on every entry to START
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    bit_idx_next = bit_idx;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_next   = S_DATA;
          bit_idx_next = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next frame when data is waiting.
        if (baud_done) begin
          if (!empty) begin
            state_next = S_START;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: line level for the state being entered, irq from current state
  always_comb begin
    tx_next  = 1'b1;
    irq_next = irq_en & empty & ~busy;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shreg[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = ^shreg;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

  // Baud counter restarts on each state entry and at each bit boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if ((state_next != state) || baud_done || (state == S_IDLE)) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
      bit_idx <= bit_idx_next;
      if (pop) begin
        shreg <= fifo_mem[rd_ptr];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      tx  <= 1'b1;
      irq <= 1'b0;
    end else begin
      tx  <= tx_next;
      irq <= irq_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read path (same-cycle load data)
  // ---------------------------------------------------------------------------
  always_comb begin
    Read_data = '0;
    if (MemRead) begin
      if (sel_stat) begin
        Read_data = {23'd0, 5'(count), overflow, empty, full, busy};
      end else if (sel_ctrl) begin
        Read_data = {31'd0, irq_en};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Testbench for uart_tx_peripheral (BAUD_DIV=4, FIFO_DEPTH=4).
// A queue-based reference model tracks FIFO contents and the expected line
// level cycle by cycle; register vectors and frame-timing scenarios add
// constant-valued checks on top.
module tb_uart_tx_peripheral;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h4000_0020;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int FR = int'(NBITS * BAUD);

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        tx;
  logic        irq;

  uart_tx_peripheral #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Read_data (Read_data),
    .tx        (tx),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_fifo[$];
  bit          m_line[$];   // expected tx level for the current and upcoming cycles
  bit          m_ovf;
  bit          m_irq_en;
  bit          m_irq;
  logic [31:0] last_rd;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  int unsigned r;
  int unsigned pst;

  function automatic void check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endfunction

  function automatic void check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (m_line.size() != 0);
    s[1]   = (m_fifo.size() == DEPTH);
    s[2]   = (m_fifo.size() == 0);
    s[3]   = m_ovf;
    s[8:4] = 5'(m_fifo.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read();
    if (!MemRead) return '0;
    if (Address == BASE + 32'd4) return m_status();
    if (Address == BASE + 32'd8) return {31'd0, m_irq_en};
    return '0;
  endfunction

  // Apply one clock edge to the model using the inputs currently on the bus.
  task automatic m_edge();
    bit         pop;
    bit         ovf_set;
    logic [7:0] b;
    if (reset) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf    = 0;
      m_irq_en = 0;
      m_irq    = 0;
      return;
    end
    m_irq = m_irq_en && (m_fifo.size() == 0) && (m_line.size() == 0);
    if (m_line.size() != 0) void'(m_line.pop_front());
    pop = (m_line.size() == 0) && (m_fifo.size() != 0);
    if (pop) begin
      b = m_fifo.pop_front();
      for (int k = 0; k < int'(BAUD); k++) m_line.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < int'(BAUD); k++) m_line.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      for (int k = 0; k < int'(BAUD); k++) m_line.push_back(^b);
`endif
      for (int k = 0; k < int'(BAUD); k++) m_line.push_back(1'b1);
    end
    ovf_set = 0;
    if (MemWrite && Address == BASE) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(Write_data[7:0]);
      else ovf_set = 1;
    end
    if (MemWrite && Address == BASE + 32'd8) begin
      m_irq_en = Write_data[0];
      if (Write_data[1]) m_ovf = 0;
    end
    if (ovf_set) m_ovf = 1;
  endtask

  // One clock: check the combinational read before the edge, outputs after it.
  task automatic cycle();
    #1;
    last_rd = Read_data;
    check32("read_data", Read_data, m_read());
    @(posedge clk);
    m_edge();
    #1;
    check1("tx", tx, (m_line.size() != 0) ? m_line[0] : 1'b1);
    check1("irq", irq, m_irq);
  endtask

  task automatic op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    MemWrite   = we;
    MemRead    = re;
    Address    = a;
    Write_data = d;
    cycle();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    op(1'b0, 1'b1, a, 32'd0);
    check32(nm, last_rd, exp);
  endtask

  task automatic check_frame(input logic [10:0] f, input string nm);
    for (int j = 0; j < FR; j++) begin
      cycle();
      check1(nm, tx, f[j / int'(BAUD)]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    idle(2);
    reset = 1'b0;
    check1("reset_tx", tx, 1'b1);
    check1("reset_irq", irq, 1'b0);
    rd(BASE + 32'd4, 32'h4, "reset_status");

    // Register access vectors: {we, re, addr, wdata, expected Read_data}
    tbl[0]  = '{1'b0, 1'b1, BASE + 32'd4,  32'd0,          32'h4};
    tbl[1]  = '{1'b0, 1'b1, BASE,          32'd0,          32'h0};
    tbl[2]  = '{1'b0, 1'b1, BASE + 32'd8,  32'd0,          32'h0};
    tbl[3]  = '{1'b1, 1'b1, BASE + 32'd8,  32'd3,          32'h0};
    tbl[4]  = '{1'b0, 1'b1, BASE + 32'd8,  32'd0,          32'h1};
    tbl[5]  = '{1'b0, 1'b1, BASE + 32'd5,  32'd0,          32'h0};
    tbl[6]  = '{1'b0, 1'b1, BASE + 32'd12, 32'd0,          32'h0};
    tbl[7]  = '{1'b1, 1'b0, BASE + 32'd1,  32'hFF,         32'h0};
    tbl[8]  = '{1'b1, 1'b0, BASE + 32'd4,  32'hFFFF_FFFF,  32'h0};
    tbl[9]  = '{1'b0, 1'b1, BASE + 32'd4,  32'd0,          32'h4};
    tbl[10] = '{1'b0, 1'b0, BASE + 32'd4,  32'd0,          32'h0};
    tbl[11] = '{1'b1, 1'b0, BASE + 32'd8,  32'd0,          32'h0};
    foreach (tbl[i]) begin
      op(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
      check32("vector", last_rd, tbl[i].exp);
    end
    rd(BASE + 32'd8, 32'h0, "ctrl_cleared");
    idle(2);

    // Single frame of 0xA5, then back to idle
    op(1'b1, 1'b0, BASE, 32'hA5);
`ifdef UART_TX_PARITY_EN
    check_frame({1'b1, 1'b0, 8'hA5, 1'b0}, "frame_a5");
`else
    check_frame({1'b1, 1'b1, 8'hA5, 1'b0}, "frame_a5");
`endif
    idle(1);
    rd(BASE + 32'd4, 32'h4, "idle_after_a5");

    // Three back-to-back frames; count steps down at each pop edge
    op(1'b1, 1'b0, BASE, 32'h01);
    op(1'b1, 1'b0, BASE, 32'h02);
    op(1'b1, 1'b0, BASE, 32'h03);
    rd(BASE + 32'd4, 32'h21, "b2b_cnt2");
    idle(FR - 3);
    rd(BASE + 32'd4, 32'h21, "b2b_before_pop2");
    rd(BASE + 32'd4, 32'h11, "b2b_after_pop2");
    idle(FR - 2);
    rd(BASE + 32'd4, 32'h11, "b2b_before_pop3");
    rd(BASE + 32'd4, 32'h05, "b2b_after_pop3");
    idle(FR + 10);
    rd(BASE + 32'd4, 32'h04, "b2b_done");

    // Overflow: fill while busy, drop the 5th, clear, then push+pop while full
    op(1'b1, 1'b0, BASE, 32'h10);
    idle(2);
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, BASE, 32'h20 + 32'(i));
    rd(BASE + 32'd4, 32'h4B, "overflow_full");
    op(1'b1, 1'b0, BASE + 32'd8, 32'h2);
    rd(BASE + 32'd4, 32'h43, "overflow_cleared");
    idle(FR - 10);
    op(1'b1, 1'b0, BASE, 32'h99);
    rd(BASE + 32'd4, 32'h43, "push_pop_full");
    idle(5 * FR + 10);
    rd(BASE + 32'd4, 32'h04, "overflow_drained");

    // Interrupt: low while sending, high one cycle after the frame ends
    op(1'b1, 1'b0, BASE + 32'd8, 32'h1);
    op(1'b1, 1'b0, BASE, 32'h55);
    for (int j = 0; j <= FR; j++) begin
      cycle();
      check1("irq_low_busy", irq, 1'b0);
    end
    cycle();
    check1("irq_rise", irq, 1'b1);
    idle(5);
    check1("irq_hold", irq, 1'b1);
    op(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    idle(2);

    // Reset mid-DATA of the second frame aborts everything
    op(1'b1, 1'b0, BASE, 32'h11);
    op(1'b1, 1'b0, BASE, 32'h22);
    idle(FR + 18);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check1("abort_tx", tx, 1'b1);
    rd(BASE + 32'd4, 32'h4, "abort_status");
    for (int j = 0; j < 2 * FR; j++) begin
      cycle();
      check1("abort_quiet", tx, 1'b1);
    end

`ifdef UART_TX_PARITY_EN
    // Parity frame with a STATUS load running through it
    op(1'b1, 1'b0, BASE, 32'h07);
    MemRead = 1'b1;
    Address = BASE + 32'd4;
    check_frame({1'b1, 1'b1, 8'h07, 1'b0}, "frame_parity");
    check32("busy_in_frame", last_rd, 32'h05);
    MemRead = 1'b0;
    idle(5);
`endif

    // Randomized traffic against the model; alternate heavy and light store phases
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 999);
      pst = (((i / 300) % 2) == 0) ? 150 : 20;
      reset      = (r == 999);
      MemWrite   = 1'b0;
      MemRead    = 1'($urandom_range(0, 1));
      Write_data = $urandom();
      case ($urandom_range(0, 4))
        0:       Address = BASE;
        1:       Address = BASE + 32'd4;
        2:       Address = BASE + 32'd8;
        3:       Address = BASE + 32'd6;
        default: Address = $urandom();
      endcase
      if (r < pst) begin
        MemWrite = 1'b1;
        Address  = BASE;
      end else if (r < pst + 30) begin
        MemWrite = 1'b1;
        Address  = BASE + 32'd8;
      end else if (r < pst + 40) begin
        MemWrite = 1'b1;
        Address  = BASE + 32'($urandom_range(1, 15));
      end
      cycle();
    end
    reset    = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
